// File: rtl/hit_judge.sv
// Rhythm-game hit judge: scrolls a 4-lane note grid, judges synchronized pad
// strikes against row 0, keeps score and miss counts, and runs the
// IDLE/PLAY/OVER game state machine.
module hit_judge #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MISS_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 stop,
    input  logic [3:0]           note_in,
    input  logic [3:0]           pad,
    output logic [4*DEPTH-1:0]   grid,
    output logic [15:0]          score,
    output logic [3:0]           misses,
    output logic                 playing,
    output logic                 game_over,
    output logic                 hit_ok,
    output logic                 hit_bad
);

    localparam int unsigned LANES   = 4;
    localparam int unsigned GRID_W  = LANES * DEPTH;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Count of set bits in one lane vector (0..4).
    function automatic logic [CNT_W-1:0] popcnt4(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Pad conditioning flops.
    logic [LANES-1:0] pad_s1_q, pad_s1_d;
    logic [LANES-1:0] pad_s2_q, pad_s2_d;
    logic [LANES-1:0] pad_prev_q, pad_prev_d;
    logic [LANES-1:0] strike_q, strike_d;

    // Game state flops.
    state_e              state_q, state_d;
    logic [GRID_W-1:0]   grid_q, grid_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [MISS_W-1:0]   misses_q, misses_d;
    logic                hit_ok_q, hit_ok_d;
    logic                hit_bad_q, hit_bad_d;
    logic                playing_q, playing_d;
    logic                game_over_q, game_over_d;

    // Judgement intermediates.
    logic [LANES-1:0]    row0;
    logic [LANES-1:0]    hits;
    logic [LANES-1:0]    wrong;
    logic [LANES-1:0]    row0_left;
    logic [LANES-1:0]    drops;
    logic [CNT_W-1:0]    hit_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_sat;
    logic [MISS_W:0]     miss_sum;
    logic [MISS_W-1:0]   miss_sat;
    logic                limit_hit;
    logic [GRID_W-1:0]   grid_play;

    // Two-flop synchronizer plus rising-edge detect; strike is registered so a
    // press appears as a one-clk strike three edges after the raw rise.
    always_comb begin
        pad_s1_d   = pad;
        pad_s2_d   = pad_s1_q;
        pad_prev_d = pad_s2_q;
        strike_d   = pad_s2_q & ~pad_prev_q;
    end

    // Strikes are judged against the pre-shift row 0; notes hit this clk are
    // removed before the tick decides which notes drop off the bottom.
    always_comb begin
        row0      = grid_q[LANES-1:0];
        hits      = strike_q & row0;
        wrong     = strike_q & ~row0;
        row0_left = row0 & ~strike_q;
        drops     = tick ? row0_left : '0;

        hit_cnt   = popcnt4(hits);
        miss_cnt  = MISS_W'(popcnt4(wrong)) + MISS_W'(popcnt4(drops));

        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hit_cnt);
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

        miss_sum  = {1'b0, misses_q} + (MISS_W + 1)'(miss_cnt);
        limit_hit = (miss_sum >= (MISS_W + 1)'(MISS_LIMIT));
        miss_sat  = limit_hit ? MISS_W'(MISS_LIMIT) : miss_sum[MISS_W-1:0];

        if (tick) begin
            grid_play = {note_in, grid_q[GRID_W-1:LANES]};
        end else begin
            grid_play = {grid_q[GRID_W-1:LANES], row0_left};
        end
    end

    // Next-state and datapath updates; stop has priority over start.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        score_d   = score_q;
        misses_d  = misses_q;
        hit_ok_d  = 1'b0;
        hit_bad_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    grid_d = '0;
                end else if (start) begin
                    state_d  = ST_PLAY;
                    grid_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    grid_d  = '0;
                end else begin
                    grid_d    = grid_play;
                    score_d   = score_sat;
                    misses_d  = miss_sat;
                    hit_ok_d  = (hit_cnt != '0);
                    hit_bad_d = (miss_cnt != '0);
                    if (limit_hit) begin
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    grid_d  = '0;
                end else if (start) begin
                    state_d  = ST_PLAY;
                    grid_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grid_d  = '0;
            end
        endcase

        playing_d   = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    // All state flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_s1_q    <= '0;
            pad_s2_q    <= '0;
            pad_prev_q  <= '0;
            strike_q    <= '0;
            state_q     <= ST_IDLE;
            grid_q      <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            hit_ok_q    <= 1'b0;
            hit_bad_q   <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            pad_s1_q    <= pad_s1_d;
            pad_s2_q    <= pad_s2_d;
            pad_prev_q  <= pad_prev_d;
            strike_q    <= strike_d;
            state_q     <= state_d;
            grid_q      <= grid_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            hit_ok_q    <= hit_ok_d;
            hit_bad_q   <= hit_bad_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign grid      = grid_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;
    assign hit_ok    = hit_ok_q;
    assign hit_bad   = hit_bad_q;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed game scenarios followed by
// random play, all checked against a lane/row reference model of the rules.
module tb_hit_judge;

    localparam int DEPTH      = 16;
    localparam int MISS_LIMIT = 8;
    localparam int IDLE = 0;
    localparam int PLAY = 1;
    localparam int OVER = 2;

    logic                clk;
    logic                rst_n;
    logic                tick;
    logic                start;
    logic                stop;
    logic [3:0]          note_in;
    logic [3:0]          pad;
    logic [4*DEPTH-1:0]  grid;
    logic [15:0]         score;
    logic [3:0]          misses;
    logic                playing;
    logic                game_over;
    logic                hit_ok;
    logic                hit_bad;

    hit_judge #(.DEPTH(DEPTH), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .note_in(note_in), .pad(pad), .grid(grid), .score(score),
        .misses(misses), .playing(playing), .game_over(game_over),
        .hit_ok(hit_ok), .hit_bad(hit_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [3:0] m_row [DEPTH];
    int         m_score;
    int         m_misses;
    int         m_state;
    bit         m_ok;
    bit         m_bad;
    logic [3:0] pad_hist [4];   // pad_hist[k] = pad seen k+1 edges ago

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_row[i] = 4'b0;
        for (int i = 0; i < 4; i++) pad_hist[i] = 4'b0;
        m_score = 0; m_misses = 0; m_state = IDLE; m_ok = 0; m_bad = 0;
    endtask

    // One rising edge of the game rules with the inputs currently applied.
    task automatic model_edge();
        logic [3:0] strike;
        int nh, nm;
        strike = pad_hist[2] & ~pad_hist[3];
        for (int i = 3; i > 0; i--) pad_hist[i] = pad_hist[i-1];
        pad_hist[0] = pad;
        m_ok = 0; m_bad = 0;
        if (stop) begin
            for (int i = 0; i < DEPTH; i++) m_row[i] = 4'b0;
            m_state = IDLE;
        end else if (start && m_state != PLAY) begin
            for (int i = 0; i < DEPTH; i++) m_row[i] = 4'b0;
            m_score = 0; m_misses = 0; m_state = PLAY;
        end else if (m_state == PLAY) begin
            nh = 0; nm = 0;
            for (int l = 0; l < 4; l++) begin
                if (strike[l]) begin
                    if (m_row[0][l]) begin nh++; m_row[0][l] = 1'b0; end
                    else nm++;
                end
            end
            if (tick) begin
                for (int l = 0; l < 4; l++) if (m_row[0][l]) nm++;
                for (int i = 0; i < DEPTH-1; i++) m_row[i] = m_row[i+1];
                m_row[DEPTH-1] = note_in;
            end
            m_score  = (m_score + nh > 65535) ? 65535 : m_score + nh;
            m_misses = (m_misses + nm > MISS_LIMIT) ? MISS_LIMIT : m_misses + nm;
            if (m_misses == MISS_LIMIT) m_state = OVER;
            m_ok  = (nh > 0);
            m_bad = (nm > 0);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4*DEPTH-1:0] eg;
        for (int i = 0; i < DEPTH; i++) eg[4*i +: 4] = m_row[i];
        n_cmp++;
        assert (grid === eg) else begin
            n_fail++; $error("FAIL %s grid: observed %h expected %h", tag, grid, eg);
        end
        n_cmp++;
        assert (score === 16'(m_score)) else begin
            n_fail++; $error("FAIL %s score: observed %0d expected %0d", tag, score, m_score);
        end
        n_cmp++;
        assert (misses === 4'(m_misses)) else begin
            n_fail++; $error("FAIL %s misses: observed %0d expected %0d", tag, misses, m_misses);
        end
        n_cmp++;
        assert (playing === (m_state == PLAY)) else begin
            n_fail++; $error("FAIL %s playing: observed %b expected %b", tag, playing, m_state == PLAY);
        end
        n_cmp++;
        assert (game_over === (m_state == OVER)) else begin
            n_fail++; $error("FAIL %s game_over: observed %b expected %b", tag, game_over, m_state == OVER);
        end
        n_cmp++;
        assert (hit_ok === m_ok) else begin
            n_fail++; $error("FAIL %s hit_ok: observed %b expected %b", tag, hit_ok, m_ok);
        end
        n_cmp++;
        assert (hit_bad === m_bad) else begin
            n_fail++; $error("FAIL %s hit_bad: observed %b expected %b", tag, hit_bad, m_bad);
        end
    endtask

    // Advance one clock, update the model, then check just after the edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++; $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b1; tick = 0; start = 0; stop = 0; note_in = 4'b0; pad = 4'b0;
        #2 rst_n = 1'b0;
        cyc("reset");
        cyc("reset");
        expect_val("reset_grid", int'(grid != '0), 0);
        #2 rst_n = 1'b1;
        cyc("idle");

        // Start a game.
        start = 1; cyc("start"); start = 0;
        expect_bit("start_playing", playing, 1'b1);

        // Scroll: a single note travels to row 0 and is dropped on the next tick.
        tick = 1; note_in = 4'b0001; cyc("scroll_in");
        note_in = 4'b0000;
        for (int i = 0; i < DEPTH-1; i++) cyc("scroll");
        tick = 0;
        expect_val("scroll_row0", int'(grid[3:0]), 1);
        tick = 1; cyc("scroll_drop"); tick = 0;
        expect_val("drop_misses", int'(misses), 1);
        expect_bit("drop_hit_bad", hit_bad, 1'b1);
        cyc("drop_after");
        expect_bit("drop_hit_bad_once", hit_bad, 1'b0);

        // Correct hit on lane 2.
        tick = 1; note_in = 4'b0100; cyc("hit_in");
        note_in = 4'b0000;
        for (int i = 0; i < DEPTH-1; i++) cyc("hit_scroll");
        tick = 0;
        pad = 4'b0100; cyc("hit_press");
        pad = 4'b0000;
        cyc("hit_wait"); cyc("hit_wait");
        cyc("hit_judge");
        expect_val("hit_score", int'(score), 1);
        expect_bit("hit_ok_pulse", hit_ok, 1'b1);
        expect_val("hit_row0", int'(grid[3:0]), 0);
        expect_val("hit_misses", int'(misses), 1);
        cyc("hit_after");
        expect_bit("hit_ok_once", hit_ok, 1'b0);

        // Strike on lane 0 in the same clk as a tick with row 0 = 0011.
        tick = 1; note_in = 4'b0011; cyc("col_in");
        note_in = 4'b0000;
        for (int i = 0; i < DEPTH-1; i++) cyc("col_scroll");
        tick = 0;
        pad = 4'b0001; cyc("col_press");
        pad = 4'b0000;
        cyc("col_wait"); cyc("col_wait");
        tick = 1; cyc("col_judge"); tick = 0;
        expect_val("col_score", int'(score), 2);
        expect_val("col_misses", int'(misses), 2);
        expect_bit("col_hit_ok", hit_ok, 1'b1);
        expect_bit("col_hit_bad", hit_bad, 1'b1);

        // start and stop together: stop wins, score held.
        start = 1; stop = 1; cyc("prio"); start = 0; stop = 0;
        expect_bit("prio_playing", playing, 1'b0);
        expect_val("prio_score", int'(score), 2);
        cyc("prio_idle");

        // Game over after MISS_LIMIT wrong strikes; grid frozen afterwards.
        start = 1; cyc("go_start"); start = 0;
        tick = 1; note_in = 4'b1111; cyc("go_note"); tick = 0; note_in = 4'b0;
        for (int k = 0; k < MISS_LIMIT; k++) begin
            pad = 4'b0001; cyc("go_press");
            pad = 4'b0000; cyc("go_release");
        end
        for (int k = 0; k < 4; k++) cyc("go_flush");
        expect_val("go_misses", int'(misses), MISS_LIMIT);
        expect_bit("go_game_over", game_over, 1'b1);
        expect_bit("go_playing", playing, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick = 1; note_in = 4'($urandom); pad = 4'($urandom); cyc("go_frozen");
        end
        tick = 0; note_in = 4'b0; pad = 4'b0;
        expect_val("go_grid_frozen", int'(grid[4*DEPTH-1 -: 4]), 15);
        for (int k = 0; k < 4; k++) cyc("go_settle");
        start = 1; cyc("go_restart"); start = 0;
        expect_bit("go_restart_playing", playing, 1'b1);
        expect_val("go_restart_score", int'(score), 0);
        expect_val("go_restart_misses", int'(misses), 0);

        // Asynchronous reset mid-game with a nonzero grid.
        for (int k = 0; k < 4; k++) begin
            tick = 1; note_in = 4'b1010; cyc("rst_fill");
        end
        tick = 0; note_in = 4'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        cyc("rst_hold");
        #2 rst_n = 1'b1;
        cyc("rst_release");

        // Random play.
        for (int k = 0; k < 800; k++) begin
            tick    = ($urandom_range(0, 3) == 0);
            note_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            pad     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pad;
            start   = ($urandom_range(0, 39) == 0);
            stop    = ($urandom_range(0, 119) == 0);
            cyc("random");
        end
        tick = 0; start = 0; stop = 0; pad = 4'b0;
        cyc("random_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
